draw_rect_bounce: RTL and testbench

//  Pixel-pipeline stage directly downstream of vga_timing, at 800x600, 40 MHz pclk.

---
 rtl/draw_rect_bounce.sv | 207 ++++++++++++++++++++
 tb/tb_draw_rect_bounce.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/draw_rect_bounce.sv
// draw_rect_bounce: overlays a bouncing solid rectangle on the vga_timing pixel stream.
// Two-stage pipeline: S1 registers timing and the rectangle hit test, S2 composites the colour.
// The rectangle position advances once per frame on the rising edge of vblnk_in.
module draw_rect_bounce #(
    parameter int unsigned H_ACTIVE   = 800,
    parameter int unsigned V_ACTIVE   = 600,
    parameter int unsigned RECT_W     = 64,
    parameter int unsigned RECT_H     = 48,
    parameter logic [11:0] RECT_COLOR = 12'hf_8_0,
    parameter int unsigned STEP       = 2,
    parameter int unsigned X_INIT     = 100,
    parameter int unsigned Y_INIT     = 100
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        enable,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] rect_x,
    output logic [10:0] rect_y
);

    localparam int unsigned CNT_W = 11;
    localparam int unsigned CMP_W = 12;
    localparam int unsigned RGB_W = 12;

    localparam logic [CMP_W-1:0] H_LIM    = CMP_W'(H_ACTIVE);
    localparam logic [CMP_W-1:0] V_LIM    = CMP_W'(V_ACTIVE);
    localparam logic [CMP_W-1:0] RECT_W_C = CMP_W'(RECT_W);
    localparam logic [CMP_W-1:0] RECT_H_C = CMP_W'(RECT_H);
    localparam logic [CMP_W-1:0] STEP_W   = CMP_W'(STEP);
    localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
    localparam logic [CNT_W-1:0] X_MAX    = CNT_W'(H_ACTIVE - RECT_W);
    localparam logic [CNT_W-1:0] Y_MAX    = CNT_W'(V_ACTIVE - RECT_H);
    localparam logic [CNT_W-1:0] X_RST    = CNT_W'(X_INIT);
    localparam logic [CNT_W-1:0] Y_RST    = CNT_W'(Y_INIT);

    localparam logic [0:0] INC = 1'b0;
    localparam logic [0:0] DEC = 1'b1;

    // Stage 1 registers
    logic [CNT_W-1:0] hcount_s1;
    logic [CNT_W-1:0] vcount_s1;
    logic             hsync_s1;
    logic             vsync_s1;
    logic             hblnk_s1;
    logic             vblnk_s1;
    logic [RGB_W-1:0] rgb_s1;
    logic             in_rect_s1;

    // Motion state
    logic [0:0]       x_state;
    logic [0:0]       x_state_nxt;
    logic [0:0]       y_state;
    logic [0:0]       y_state_nxt;
    logic [CNT_W-1:0] rect_x_nxt;
    logic [CNT_W-1:0] rect_y_nxt;
    logic             vblnk_prev;

    // Widened operands so every compare sum is 12-bit and cannot wrap
    logic [CMP_W-1:0] hc_w;
    logic [CMP_W-1:0] vc_w;
    logic [CMP_W-1:0] rx_w;
    logic [CMP_W-1:0] ry_w;
    logic             in_rect_c;
    logic             tick_c;
    logic             move_c;

    assign hc_w = {1'b0, hcount_in};
    assign vc_w = {1'b0, vcount_in};
    assign rx_w = {1'b0, rect_x};
    assign ry_w = {1'b0, rect_y};

    // Rectangle hit test against the current (frame-stable) position
    assign in_rect_c = (hc_w >= rx_w) && (hc_w < rx_w + RECT_W_C) &&
                       (vc_w >= ry_w) && (vc_w < ry_w + RECT_H_C);

    // One tick per frame on the vblank rising edge
    assign tick_c = vblnk_in && !vblnk_prev;
    assign move_c = tick_c && enable;

    // Stage 1: register inputs and the hit test
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_s1  <= '0;
            vcount_s1  <= '0;
            hsync_s1   <= 1'b0;
            vsync_s1   <= 1'b0;
            hblnk_s1   <= 1'b1;
            vblnk_s1   <= 1'b1;
            rgb_s1     <= '0;
            in_rect_s1 <= 1'b0;
        end else begin
            hcount_s1  <= hcount_in;
            vcount_s1  <= vcount_in;
            hsync_s1   <= hsync_in;
            vsync_s1   <= vsync_in;
            hblnk_s1   <= hblnk_in;
            vblnk_s1   <= vblnk_in;
            rgb_s1     <= rgb_in;
            in_rect_s1 <= in_rect_c;
        end
    end

    // Stage 2: composite colour; blanked pixels pass the background through
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            vsync_out  <= 1'b0;
            hblnk_out  <= 1'b1;
            vblnk_out  <= 1'b1;
            rgb_out    <= '0;
        end else begin
            hcount_out <= hcount_s1;
            vcount_out <= vcount_s1;
            hsync_out  <= hsync_s1;
            vsync_out  <= vsync_s1;
            hblnk_out  <= hblnk_s1;
            vblnk_out  <= vblnk_s1;
            rgb_out    <= (in_rect_s1 && !hblnk_s1 && !vblnk_s1) ? RECT_COLOR : rgb_s1;
        end
    end

    // Position and direction registers; previous vblank resets high to suppress a tick at release
    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            rect_x     <= X_RST;
            rect_y     <= Y_RST;
            x_state    <= INC;
            y_state    <= INC;
            vblnk_prev <= 1'b1;
        end else begin
            rect_x     <= rect_x_nxt;
            rect_y     <= rect_y_nxt;
            x_state    <= x_state_nxt;
            y_state    <= y_state_nxt;
            vblnk_prev <= vblnk_in;
        end
    end

    // X axis: step, clamping at the right edge or at zero and reversing
    always_comb begin
        x_state_nxt = x_state;
        rect_x_nxt  = rect_x;
        if (move_c) begin
            case (x_state)
                INC: begin
                    if (rx_w + STEP_W + RECT_W_C > H_LIM) begin
                        rect_x_nxt  = X_MAX;
                        x_state_nxt = DEC;
                    end else begin
                        rect_x_nxt = rect_x + STEP_C;
                    end
                end
                default: begin
                    if (rx_w < STEP_W) begin
                        rect_x_nxt  = '0;
                        x_state_nxt = INC;
                    end else begin
                        rect_x_nxt = rect_x - STEP_C;
                    end
                end
            endcase
        end
    end

    // Y axis: same bounce rule against the bottom edge and zero
    always_comb begin
        y_state_nxt = y_state;
        rect_y_nxt  = rect_y;
        if (move_c) begin
            case (y_state)
                INC: begin
                    if (ry_w + STEP_W + RECT_H_C > V_LIM) begin
                        rect_y_nxt  = Y_MAX;
                        y_state_nxt = DEC;
                    end else begin
                        rect_y_nxt = rect_y + STEP_C;
                    end
                end
                default: begin
                    if (ry_w < STEP_W) begin
                        rect_y_nxt  = '0;
                        y_state_nxt = INC;
                    end else begin
                        rect_y_nxt = rect_y - STEP_C;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_draw_rect_bounce.sv
// Bench for draw_rect_bounce: scoreboard on the pixel stream plus direct position checks.
`timescale 1ns/1ps
module tb_draw_rect_bounce;

    logic        pclk = 1'b0;
    logic        rst;
    logic        en_a;
    logic        en_b;
    logic [10:0] hcount_in;
    logic [10:0] vcount_in;
    logic        hsync_in;
    logic        vsync_in;
    logic        hblnk_in;
    logic        vblnk_in;
    logic [11:0] rgb_in;

    logic [10:0] hcount_a, vcount_a, rect_x_a, rect_y_a;
    logic        hsync_a, vsync_a, hblnk_a, vblnk_a;
    logic [11:0] rgb_a;
    logic [10:0] hcount_b, vcount_b, rect_x_b, rect_y_b;
    logic        hsync_b, vsync_b, hblnk_b, vblnk_b;
    logic [11:0] rgb_b;

    typedef struct {
        int          tag;
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic [11:0] rgb_in;
        logic [11:0] rgb_exp;
    } exp_t;

    exp_t sb[$];
    int   edge_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;

    always #5 pclk = ~pclk;

    always @(posedge pclk) edge_cnt <= edge_cnt + 1;

    draw_rect_bounce u_a (
        .pclk(pclk), .rst(rst), .enable(en_a),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_a), .vcount_out(vcount_a),
        .hsync_out(hsync_a), .vsync_out(vsync_a),
        .hblnk_out(hblnk_a), .vblnk_out(vblnk_a), .rgb_out(rgb_a),
        .rect_x(rect_x_a), .rect_y(rect_y_a)
    );

    // Second instance sits next to both bounce points
    draw_rect_bounce #(.RECT_H(599), .X_INIT(733), .Y_INIT(1)) u_b (
        .pclk(pclk), .rst(rst), .enable(en_b),
        .hcount_in(hcount_in), .vcount_in(vcount_in),
        .hsync_in(hsync_in), .vsync_in(vsync_in),
        .hblnk_in(hblnk_in), .vblnk_in(vblnk_in), .rgb_in(rgb_in),
        .hcount_out(hcount_b), .vcount_out(vcount_b),
        .hsync_out(hsync_b), .vsync_out(vsync_b),
        .hblnk_out(hblnk_b), .vblnk_out(vblnk_b), .rgb_out(rgb_b),
        .rect_x(rect_x_b), .rect_y(rect_y_b)
    );

    // Expected colour for the default 64x48 orange rectangle at (rx, ry)
    function automatic logic [11:0] model_rgb(input logic [10:0] h, v, input logic hb, vb,
                                              input logic [11:0] rgb, input logic [10:0] rx, ry);
        int hi, vi, xi, yi;
        hi = int'(h); vi = int'(v); xi = int'(rx); yi = int'(ry);
        if (!hb && !vb && hi >= xi && hi < xi + 64 && vi >= yi && vi < yi + 48)
            return 12'hf80;
        return rgb;
    endfunction

    // Scoreboard: each entry is due on the negedge after its second sampling edge
    always @(negedge pclk) begin
        exp_t e;
        if (!rst) begin
            while (sb.size() > 0 && sb[0].tag + 1 <= edge_cnt) begin
                e = sb.pop_front();
                checks++;
                if (hcount_a !== e.h) begin
                    errors++;
                    $display("FAIL sb_hcount tag=%0d got %0d want %0d", e.tag, hcount_a, e.h);
                end
                checks++;
                if (vcount_a !== e.v) begin
                    errors++;
                    $display("FAIL sb_vcount tag=%0d got %0d want %0d", e.tag, vcount_a, e.v);
                end
                checks++;
                if ({hsync_a, vsync_a, hblnk_a, vblnk_a} !== {e.hs, e.vs, e.hb, e.vb}) begin
                    errors++;
                    $display("FAIL sb_syncblank tag=%0d got %b want %b", e.tag,
                             {hsync_a, vsync_a, hblnk_a, vblnk_a}, {e.hs, e.vs, e.hb, e.vb});
                end
                checks++;
                if (rgb_a !== e.rgb_exp) begin
                    errors++;
                    $display("FAIL sb_rgb tag=%0d h=%0d v=%0d got %h want %h",
                             e.tag, e.h, e.v, rgb_a, e.rgb_exp);
                end
                checks++;
                if ({hcount_b, vcount_b, hsync_b, vsync_b, hblnk_b, vblnk_b} !==
                    {e.h, e.v, e.hs, e.vs, e.hb, e.vb}) begin
                    errors++;
                    $display("FAIL sb_b_timing tag=%0d got %0d/%0d want %0d/%0d",
                             e.tag, hcount_b, vcount_b, e.h, e.v);
                end
                if (e.hb || e.vb) begin
                    checks++;
                    if (rgb_b !== e.rgb_in) begin
                        errors++;
                        $display("FAIL sb_b_blank_rgb tag=%0d got %h want %h", e.tag, rgb_b, e.rgb_in);
                    end
                end
            end
        end
    end

    // Drive one pixel (called at a negedge) and record its expected output
    task automatic drive(input logic [10:0] h, v, input logic hb, vb,
                         input logic [11:0] rgb, input logic [10:0] rx, ry);
        exp_t e;
        hcount_in = h;
        vcount_in = v;
        hsync_in  = h[3];
        vsync_in  = v[2];
        hblnk_in  = hb;
        vblnk_in  = vb;
        rgb_in    = rgb;
        e.tag     = edge_cnt + 1;
        e.h       = h;
        e.v       = v;
        e.hs      = h[3];
        e.vs      = v[2];
        e.hb      = hb;
        e.vb      = vb;
        e.rgb_in  = rgb;
        e.rgb_exp = model_rgb(h, v, hb, vb, rgb, rx, ry);
        sb.push_back(e);
        @(negedge pclk);
    endtask

    // A few active pixels straddling the right rectangle edge, then a vblank run
    task automatic frame(input int n_vb, input logic [10:0] rx, ry);
        for (int i = 0; i < 4; i++)
            drive(11'(rx + 11'd62 + 11'(i)), ry, 1'b0, 1'b0, 12'h5a5, rx, ry);
        for (int i = 0; i < n_vb; i++)
            drive(11'(700 + i), 11'd601, 1'b1, 1'b1, 12'(i * 7), rx, ry);
    endtask

    task automatic check_pos(input string name, input logic [10:0] got_x, got_y, want_x, want_y);
        checks++;
        if (got_x !== want_x || got_y !== want_y) begin
            errors++;
            $display("FAIL %s got x=%0d y=%0d want x=%0d y=%0d", name, got_x, got_y, want_x, want_y);
        end
    endtask

    task automatic test_reset();
        drive(11'd398, 11'd300, 1'b0, 1'b0, 12'h123, 11'd100, 11'd100);
        drive(11'd399, 11'd300, 1'b0, 1'b0, 12'h124, 11'd100, 11'd100);
        hcount_in = 11'd400;
        #2 rst = 1'b1;
        #1;
        sb.delete();
        checks++;
        if ({hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a} !==
            {11'd0, 11'd0, 1'b0, 1'b0, 1'b1, 1'b1, 12'h000}) begin
            errors++;
            $display("FAIL reset_outputs got h=%0d v=%0d sb=%b%b%b%b rgb=%h want 0 0 0011 000",
                     hcount_a, vcount_a, hsync_a, vsync_a, hblnk_a, vblnk_a, rgb_a);
        end
        check_pos("reset_pos_a", rect_x_a, rect_y_a, 11'd100, 11'd100);
        check_pos("reset_pos_b", rect_x_b, rect_y_b, 11'd733, 11'd1);
        @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);
        checks++;
        if (hcount_a !== 11'd0 || hblnk_a !== 1'b1 || rgb_a !== 12'h000) begin
            errors++;
            $display("FAIL reset_first_edge got h=%0d hb=%b rgb=%h want 0 1 000", hcount_a, hblnk_a, rgb_a);
        end
        @(negedge pclk);
        checks++;
        if (hcount_a !== 11'd400 || vcount_a !== 11'd300) begin
            errors++;
            $display("FAIL reset_second_edge got h=%0d v=%0d want 400 300", hcount_a, vcount_a);
        end
    endtask

    task automatic test_latency_hit();
        drive(11'd100, 11'd100, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd101, 11'd100, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd100, 11'd99,  1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
    endtask

    task automatic test_edges();
        drive(11'd163, 11'd120, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd164, 11'd120, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd99,  11'd120, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd120, 11'd147, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd120, 11'd148, 1'b0, 1'b0, 12'haaa, 11'd100, 11'd100);
        drive(11'd120, 11'd120, 1'b1, 1'b0, 12'h000, 11'd100, 11'd100);
        drive(11'd120, 11'd120, 1'b0, 1'b1, 12'h0f0, 11'd100, 11'd100);
        for (int i = 0; i < 10; i++)
            drive(11'($urandom_range(60, 200)), 11'($urandom_range(80, 170)),
                  1'($urandom_range(0, 3) == 0), 1'b0, 12'($urandom), 11'd100, 11'd100);
    endtask

    task automatic test_motion();
        logic [10:0] p;
        en_a = 1'b1;
        for (int f = 0; f < 3; f++) begin
            p = 11'(100 + 2 * f);
            frame(20, p, p);
            check_pos("motion_frame", rect_x_a, rect_y_a, 11'(p + 11'd2), 11'(p + 11'd2));
        end
        check_pos("motion_b_frozen", rect_x_b, rect_y_b, 11'd733, 11'd1);
        drive(11'd106, 11'd106, 1'b0, 1'b0, 12'haaa, 11'd106, 11'd106);
        drive(11'd105, 11'd106, 1'b0, 1'b0, 12'haaa, 11'd106, 11'd106);
        drive(11'd169, 11'd153, 1'b0, 1'b0, 12'haaa, 11'd106, 11'd106);
        drive(11'd170, 11'd153, 1'b0, 1'b0, 12'haaa, 11'd106, 11'd106);
        drive(11'd120, 11'd154, 1'b0, 1'b0, 12'haaa, 11'd106, 11'd106);
    endtask

    task automatic test_freeze();
        en_a = 1'b0;
        frame(6, 11'd106, 11'd106);
        check_pos("freeze_tick1", rect_x_a, rect_y_a, 11'd106, 11'd106);
        frame(6, 11'd106, 11'd106);
        check_pos("freeze_tick2", rect_x_a, rect_y_a, 11'd106, 11'd106);
        drive(11'd110, 11'd110, 1'b0, 1'b0, 12'h333, 11'd106, 11'd106);
        en_a = 1'b1;
        drive(11'd111, 11'd110, 1'b0, 1'b0, 12'h333, 11'd106, 11'd106);
        drive(11'd112, 11'd110, 1'b0, 1'b0, 12'h333, 11'd106, 11'd106);
        check_pos("freeze_midframe", rect_x_a, rect_y_a, 11'd106, 11'd106);
        frame(6, 11'd106, 11'd106);
        check_pos("freeze_next_tick", rect_x_a, rect_y_a, 11'd108, 11'd108);
        en_a = 1'b0;
    endtask

    task automatic test_bounce();
        logic [10:0] wx [3];
        logic [10:0] wy [3];
        wx[0] = 11'd735; wx[1] = 11'd736; wx[2] = 11'd734;
        wy[0] = 11'd1;   wy[1] = 11'd0;   wy[2] = 11'd1;
        en_b = 1'b1;
        for (int t = 0; t < 3; t++) begin
            frame(5, 11'd108, 11'd108);
            check_pos("bounce_b", rect_x_b, rect_y_b, wx[t], wy[t]);
        end
        check_pos("bounce_a_frozen", rect_x_a, rect_y_a, 11'd108, 11'd108);
        en_b = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en_a      = 1'b0;
        en_b      = 1'b0;
        hcount_in = '0;
        vcount_in = '0;
        hsync_in  = 1'b0;
        vsync_in  = 1'b0;
        hblnk_in  = 1'b0;
        vblnk_in  = 1'b0;
        rgb_in    = '0;
        repeat (2) @(negedge pclk);
        rst = 1'b0;
        @(negedge pclk);

        test_reset();
        test_latency_hit();
        test_edges();
        test_motion();
        test_freeze();
        test_bounce();

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge pclk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
